// File: rtl/ct_piu_l2dbg_rd_ctrl.sv
// L2-cache debug-read sequencer: validates a PIU debug read, issues one L2 access with req/gnt,
// returns each beat to the PIU and reports malformed, overlapping or timed-out reads as errors.
module ct_piu_l2dbg_rd_ctrl #(
    parameter int IDX_W   = 21,
    parameter int WAY_W   = 4,
    parameter int DATA_W  = 128,
    parameter int BEATS   = 4,
    parameter int TMO_CYC = 255
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              piu_l2cif_read_req,
    input  logic [IDX_W-1:0]  piu_l2cif_read_index,
    input  logic [WAY_W-1:0]  piu_l2cif_read_way,
    input  logic              piu_l2cif_read_tag,
    input  logic              piu_l2cif_read_tag_ecc,
    input  logic              piu_l2cif_read_data,
    input  logic              piu_l2cif_read_data_ecc,
    input  logic              l2c_dbg_gnt,
    input  logic              l2c_dbg_rvld,
    input  logic [DATA_W-1:0] l2c_dbg_rdata,
    output logic              l2cif_dbg_req,
    output logic [IDX_W-1:0]  l2cif_dbg_index,
    output logic [WAY_W-1:0]  l2cif_dbg_way,
    output logic [1:0]        l2cif_dbg_sel,
    output logic              l2cif_piu_read_data_vld,
    output logic [DATA_W-1:0] l2cif_piux_read_data,
    output logic              l2cif_piu_read_err,
    output logic              l2cif_piu_busy
);

    localparam logic [1:0]       LAST_DATA_BEAT = 2'(BEATS - 1);
    localparam logic [7:0]       TMO_LIMIT      = 8'(TMO_CYC);
    localparam logic [WAY_W-1:0] WAY_ONE        = WAY_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    function automatic logic way_onehot(input logic [WAY_W-1:0] way);
        return (way != {WAY_W{1'b0}}) && ((way & (way - WAY_ONE)) == {WAY_W{1'b0}});
    endfunction

    // Type selects are packed {data_ecc, data, tag_ecc, tag}; exactly one must be set.
    function automatic logic type_single(input logic [3:0] types);
        logic ok;
        case (types)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] type_to_sel(input logic [3:0] types);
        logic [1:0] sel;
        case (types)
            4'b0001: sel = 2'b00;
            4'b0010: sel = 2'b01;
            4'b0100: sel = 2'b10;
            4'b1000: sel = 2'b11;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    state_e              state_q,   state_d;
    logic                dbg_req_q, dbg_req_d;
    logic [IDX_W-1:0]    index_q,   index_d;
    logic [WAY_W-1:0]    way_q,     way_d;
    logic [1:0]          sel_q,     sel_d;
    logic                vld_q,     vld_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                err_q,     err_d;
    logic                busy_q,    busy_d;
    logic [1:0]          beat_q,    beat_d;
    logic [1:0]          last_q,    last_d;
    logic [7:0]          tmo_q,     tmo_d;
    logic                ovr_q,     ovr_d;

    logic [3:0]          types_s;
    logic                req_ok_s;
    logic [7:0]          tmo_inc_s;
    logic                tmo_hit_s;

    assign types_s   = {piu_l2cif_read_data_ecc, piu_l2cif_read_data,
                        piu_l2cif_read_tag_ecc, piu_l2cif_read_tag};
    assign req_ok_s  = type_single(types_s) && way_onehot(piu_l2cif_read_way);
    assign tmo_inc_s = (tmo_q < TMO_LIMIT) ? (tmo_q + 8'd1) : TMO_LIMIT;
    assign tmo_hit_s = (tmo_inc_s == TMO_LIMIT);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        dbg_req_d = dbg_req_q;
        index_d   = index_q;
        way_d     = way_q;
        sel_d     = sel_q;
        vld_d     = 1'b0;
        data_d    = data_q;
        err_d     = 1'b0;
        beat_d    = beat_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        ovr_d     = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (piu_l2cif_read_req) begin
                    if (req_ok_s) begin
                        state_d   = ST_REQ;
                        dbg_req_d = 1'b1;
                        index_d   = piu_l2cif_read_index;
                        way_d     = piu_l2cif_read_way;
                        sel_d     = type_to_sel(types_s);
                        last_d    = types_s[2] | types_s[3] ? LAST_DATA_BEAT : 2'd0;
                        beat_d    = 2'd0;
                        tmo_d     = 8'd0;
                    end else begin
                        vld_d  = 1'b1;
                        err_d  = 1'b1;
                        data_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                ovr_d = ovr_q | piu_l2cif_read_req;
                // Grant wins over a same-cycle beat, which is dropped.
                if (l2c_dbg_gnt) begin
                    state_d   = ST_WAIT;
                    dbg_req_d = 1'b0;
                    tmo_d     = 8'd0;
                end else if (tmo_hit_s) begin
                    state_d   = ST_IDLE;
                    dbg_req_d = 1'b0;
                    vld_d     = 1'b1;
                    err_d     = 1'b1;
                    data_d    = {DATA_W{1'b0}};
                    ovr_d     = 1'b0;
                    beat_d    = 2'd0;
                    tmo_d     = tmo_inc_s;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_WAIT: begin
                ovr_d = ovr_q | piu_l2cif_read_req;
                if (l2c_dbg_rvld) begin
                    vld_d  = 1'b1;
                    data_d = l2c_dbg_rdata;
                    tmo_d  = 8'd0;
                    if (beat_q == last_q) begin
                        state_d = ST_IDLE;
                        beat_d  = 2'd0;
                        err_d   = ovr_q | piu_l2cif_read_req;
                        ovr_d   = 1'b0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b1;
                    err_d   = 1'b1;
                    data_d  = {DATA_W{1'b0}};
                    ovr_d   = 1'b0;
                    beat_d  = 2'd0;
                    tmo_d   = tmo_inc_s;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                dbg_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous active-low reset abandons any read in flight.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            dbg_req_q <= 1'b0;
            index_q   <= {IDX_W{1'b0}};
            way_q     <= {WAY_W{1'b0}};
            sel_q     <= 2'b00;
            vld_q     <= 1'b0;
            data_q    <= {DATA_W{1'b0}};
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            beat_q    <= 2'd0;
            last_q    <= 2'd0;
            tmo_q     <= 8'd0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbg_req_q <= dbg_req_d;
            index_q   <= index_d;
            way_q     <= way_d;
            sel_q     <= sel_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
        end
    end

    assign l2cif_dbg_req           = dbg_req_q;
    assign l2cif_dbg_index         = index_q;
    assign l2cif_dbg_way           = way_q;
    assign l2cif_dbg_sel           = sel_q;
    assign l2cif_piu_read_data_vld = vld_q;
    assign l2cif_piux_read_data    = data_q;
    assign l2cif_piu_read_err      = err_q;
    assign l2cif_piu_busy          = busy_q;

endmodule
